alu_operand_latch: RTL and testbench
====================================

// Module: alu_operand_latch
// PURPOSE
//  Operand-pairing stage directly upstream of the shift unit (and other ALU units).
//  Captures OperandA and OperandB forward tokens that may arrive in different cycles.
//  Holds each one until its partner arrives. Presents both together to the unit with an enable.
//  Throttles each source independently with a per-source nack and observes the unit's backward token.
// PARAMETERS
//  WIDTH_DATA   32   data width of FTk_t.d (from pkg_en; shift amount uses low $clog2 bits)
//  WIDTH_STALL  8    width of saturating stall counter
// PORTS
//  clock        in   1           system clock, all state on rising edge
//  reset        in   1           synchronous, active-low reset
//  I_OperandA   in   FTk_t       source A token (.v valid, .a, .c, .r, .d)
//  I_OperandB   in   FTk_t       source B token
//  O_NackA      out  1           1 = A not accepted this cycle, source holds token
//  O_NackB      out  1           1 = B not accepted this cycle, source holds token
//  O_En         out  1           operand pair valid to downstream unit (drives I_En)
//  O_OperandA   out  FTk_t       registered A held for the unit
//  O_OperandB   out  FTk_t       registered B held for the unit
//  I_BTk        in   BTk_t       backward token from unit (.n = downstream nack)
//  O_StallCnt   out  WIDTH_STALL saturating count of cycles FULL && I_BTk.n
// BEHAVIOUR
//  Reset (reset==0 at edge):
//   - state=EMPTY; O_En=0; O_OperandA/B all fields 0; O_StallCnt=0.
//   - O_NackA=O_NackB=1 while reset is low.
//   - Held operands are discarded (mid-operation reset drops them, no partial issue).
//  States:
//   - EMPTY  = no slot held
//   - HOLD_A = A held, waiting for B
//   - HOLD_B = B held, waiting for A
//   - FULL   = both held, O_En=1
//  Release: in FULL with I_BTk.n==0 the pair is consumed at that edge. FULL with I_BTk.n==1 holds everything stable.
//  Slot free this cycle: slot empty, or (FULL and release).
//  Accept: O_NackX = ~(slot X free). X is captured at the edge when I_OperandX.v && !O_NackX.
//  Transitions (acc = accepted this edge):
//   - EMPTY : accA&accB->FULL; accA->HOLD_A; accB->HOLD_B; else EMPTY
//   - HOLD_A: accB->FULL; else HOLD_A (new A nacked)
//   - HOLD_B: accA->FULL; else HOLD_B
//   - FULL  : !release->FULL. release&accA&accB->FULL (back-to-back); release&accA->HOLD_A;
//             release&accB->HOLD_B; release only->EMPTY
//  Latency: A and B valid in cycle N (state EMPTY) -> O_En=1 in cycle N+1. Sustained throughput is 1 pair/cycle when I_BTk.n==0.
//  Output rules:
//   - O_En = (state==FULL).
//   - O_OperandX.v = O_En. Other fields are a verbatim copy of the captured token; no data modification.
//   - When not FULL, O_OperandX.d holds the last captured value (do not care for the unit, gated by .v).
//  O_StallCnt: +1 each cycle FULL && I_BTk.n. Saturates at all-ones and never wraps. Cleared only by reset.
//  Simultaneous events:
//   - Release and new arrivals in the same cycle: new tokens are written; the old pair is not re-issued.
//   - Both sources valid while one slot is occupied: only the free slot accepts.
//  No combinational path from I_OperandX to O_OperandX/O_En. O_NackX depends combinationally on state and I_BTk.n only.
// TESTING
//  1 Reset: hold reset=0 3 cycles with A,B valid -> O_En=0, O_Nack*=1, outputs 0; release -> EMPTY, Nack*=0.
//  2 Pairing: A.d=32'h8000_0001 cycle 1, B.d=4 cycle 4 -> HOLD_A cycles 2-4, O_En=1 cycle 5 with both d intact;
//    a second A sent in cycle 3 sees O_NackA=1 and is held by the source.
//  3 Back-to-back: A,B valid every cycle, I_BTk.n=0, 8 pairs -> O_En=1 for 8 consecutive cycles, in order, no loss/duplication.
//  4 Backpressure: FULL, I_BTk.n=1 for 5 cycles -> O_Operand* stable, O_NackA=O_NackB=1, O_StallCnt=5;
//    I_BTk.n->0 -> pair consumed once.
//  5 Saturation: WIDTH_STALL=4, stall 20 cycles -> O_StallCnt=15, stays 15.
//  6 Mid-op reset: state HOLD_B with B.d=7, assert reset 1 cycle, then A arrives -> state HOLD_A, B=7 never issued.

Source files
------------

// File: rtl/alu_operand_latch.sv
// Operand-pairing stage ahead of the ALU units.
// Holds A and B tokens until both are present, then issues them together.
package pkg_en;
  localparam int WIDTH_DATA = 32;

  typedef struct packed {
    logic                  v;
    logic                  a;
    logic                  c;
    logic                  r;
    logic [WIDTH_DATA-1:0] d;
  } FTk_t;

  typedef struct packed {
    logic n;
  } BTk_t;
endpackage

module alu_operand_latch
  import pkg_en::*;
#(
  parameter int WIDTH_STALL = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  FTk_t                   I_OperandA,
  input  FTk_t                   I_OperandB,
  output logic                   O_NackA,
  output logic                   O_NackB,
  output logic                   O_En,
  output FTk_t                   O_OperandA,
  output FTk_t                   O_OperandB,
  input  BTk_t                   I_BTk,
  output logic [WIDTH_STALL-1:0] O_StallCnt
);

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    HOLD_A = 2'd1,
    HOLD_B = 2'd2,
    FULL   = 2'd3
  } state_t;

  state_t state;
  state_t nextState;
  FTk_t   regA;
  FTk_t   regB;

  logic release_;
  logic holdA;
  logic holdB;
  logic freeA;
  logic freeB;
  logic accA;
  logic accB;
  logic keepA;
  logic keepB;
  logic hasA;
  logic hasB;

  assign release_ = (state == FULL) && !I_BTk.n;
  assign holdA    = (state == HOLD_A) || (state == FULL);
  assign holdB    = (state == HOLD_B) || (state == FULL);
  assign freeA    = !holdA || release_;
  assign freeB    = !holdB || release_;

  // Sources are throttled for the whole reset period.
  assign O_NackA = !reset || !freeA;
  assign O_NackB = !reset || !freeB;

  assign accA  = I_OperandA.v && !O_NackA;
  assign accB  = I_OperandB.v && !O_NackB;
  assign keepA = holdA && !release_;
  assign keepB = holdB && !release_;
  assign hasA  = keepA || accA;
  assign hasB  = keepB || accB;

  always_comb begin
    nextState = EMPTY;
    unique case ({hasA, hasB})
      2'b11:   nextState = FULL;
      2'b10:   nextState = HOLD_A;
      2'b01:   nextState = HOLD_B;
      default: nextState = EMPTY;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= EMPTY;
      regA       <= '0;
      regB       <= '0;
      O_StallCnt <= '0;
    end else begin
      state <= nextState;
      if (accA) regA <= I_OperandA;
      if (accB) regB <= I_OperandB;
      if ((state == FULL) && I_BTk.n && (O_StallCnt != '1))
        O_StallCnt <= O_StallCnt + 1'b1;
    end
  end

  assign O_En = (state == FULL);

  always_comb begin
    O_OperandA   = regA;
    O_OperandA.v = O_En;
    O_OperandB   = regB;
    O_OperandB.v = O_En;
  end

endmodule

// File: tb/tb_alu_operand_latch.sv
// Directed bench for alu_operand_latch.
// Runs with a 4-bit stall counter so saturation is reachable quickly.
module tb_alu_operand_latch;
  import pkg_en::*;

  logic       clock;
  logic       reset;
  FTk_t       opA;
  FTk_t       opB;
  logic       nackA;
  logic       nackB;
  logic       en;
  FTk_t       outA;
  FTk_t       outB;
  BTk_t       btk;
  logic [3:0] stallCnt;

  int errors = 0;
  int checks = 0;

  alu_operand_latch #(.WIDTH_STALL(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .I_OperandA (opA),
    .I_OperandB (opB),
    .O_NackA    (nackA),
    .O_NackB    (nackB),
    .O_En       (en),
    .O_OperandA (outA),
    .O_OperandB (outB),
    .I_BTk      (btk),
    .O_StallCnt (stallCnt)
  );

  initial clock = 0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic FTk_t tok(input logic [31:0] d);
    FTk_t t;
    t.v = 1'b1;
    t.a = d[0];
    t.c = d[1];
    t.r = d[2];
    t.d = d;
    return t;
  endfunction

  task automatic do_reset();
    opA   = '0;
    opB   = '0;
    btk   = '0;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    opA   = tok(32'h1234);
    opB   = tok(32'h5678);
    btk   = '0;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (en !== 1'b0 || nackA !== 1'b1 || nackB !== 1'b1) begin
        errors++;
        $display("FAIL reset_ctl: en=%b nA=%b nB=%b want 0 1 1", en, nackA, nackB);
      end
    end
    checks++;
    if (outA !== '0 || outB !== '0 || stallCnt !== 4'd0) begin
      errors++;
      $display("FAIL reset_out: A=%h B=%h cnt=%0d want 0", outA, outB, stallCnt);
    end
    opA   = '0;
    opB   = '0;
    reset = 1'b1;
    #1;
    checks++;
    if (nackA !== 1'b0 || nackB !== 1'b0) begin
      errors++;
      $display("FAIL reset_rel: nA=%b nB=%b want 0 0", nackA, nackB);
    end
  endtask

  task automatic test_pairing();
    do_reset();
    opA = tok(32'h8000_0001);
    tick();
    opA = '0;
    checks++;
    if (en !== 1'b0 || nackA !== 1'b1 || nackB !== 1'b0) begin
      errors++;
      $display("FAIL pair_holdA: en=%b nA=%b nB=%b want 0 1 0", en, nackA, nackB);
    end
    tick();
    opA = tok(32'h55);
    #1;
    checks++;
    if (nackA !== 1'b1) begin
      errors++;
      $display("FAIL pair_nack2: nA=%b want 1", nackA);
    end
    tick();
    opB = tok(32'd4);
    tick();
    opB = '0;
    checks++;
    if (en !== 1'b1 || outA.d !== 32'h8000_0001 || outB.d !== 32'd4 ||
        outA.v !== 1'b1 || outA.a !== 1'b1 || outB.r !== 1'b1) begin
      errors++;
      $display("FAIL pair_full: en=%b A=%h B=%h want 1 80000001 4", en, outA.d, outB.d);
    end
    tick();
    opA = '0;
    checks++;
    if (en !== 1'b0 || nackA !== 1'b1 || outA.v !== 1'b0) begin
      errors++;
      $display("FAIL pair_a2held: en=%b nA=%b want 0 1", en, nackA);
    end
    opB = tok(32'd9);
    tick();
    opB = '0;
    checks++;
    if (en !== 1'b1 || outA.d !== 32'h55 || outB.d !== 32'd9) begin
      errors++;
      $display("FAIL pair_second: A=%h B=%h want 55 9", outA.d, outB.d);
    end
    tick();
    checks++;
    if (en !== 1'b0) begin
      errors++;
      $display("FAIL pair_drain: en=%b want 0", en);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      opA = tok(32'd100 + i);
      opB = tok(32'd200 + i);
      #1;
      checks++;
      if (nackA !== 1'b0 || nackB !== 1'b0) begin
        errors++;
        $display("FAIL b2b_nack[%0d]: nA=%b nB=%b want 0 0", i, nackA, nackB);
      end
      tick();
      checks++;
      if (en !== 1'b1 || outA.d !== 32'd100 + i || outB.d !== 32'd200 + i) begin
        errors++;
        $display("FAIL b2b_pair[%0d]: en=%b A=%0d B=%0d want 1 %0d %0d",
                 i, en, outA.d, outB.d, 100 + i, 200 + i);
      end
    end
    opA = '0;
    opB = '0;
    tick();
    checks++;
    if (en !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: en=%b want 0", en);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    opA = tok(32'd11);
    opB = tok(32'd22);
    tick();
    btk.n = 1'b1;
    opA   = tok(32'd33);
    opB   = tok(32'd44);
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (nackA !== 1'b1 || nackB !== 1'b1) begin
        errors++;
        $display("FAIL bp_nack[%0d]: nA=%b nB=%b want 1 1", i, nackA, nackB);
      end
      tick();
      checks++;
      if (en !== 1'b1 || outA.d !== 32'd11 || outB.d !== 32'd22) begin
        errors++;
        $display("FAIL bp_stable[%0d]: en=%b A=%0d B=%0d want 1 11 22", i, en, outA.d, outB.d);
      end
    end
    checks++;
    if (stallCnt !== 4'd5) begin
      errors++;
      $display("FAIL bp_cnt: cnt=%0d want 5", stallCnt);
    end
    opA   = '0;
    opB   = '0;
    btk.n = 1'b0;
    tick();
    checks++;
    if (en !== 1'b0 || stallCnt !== 4'd5) begin
      errors++;
      $display("FAIL bp_release: en=%b cnt=%0d want 0 5", en, stallCnt);
    end
    tick();
    checks++;
    if (en !== 1'b0) begin
      errors++;
      $display("FAIL bp_once: en=%b want 0", en);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    opA = tok(32'd1);
    opB = tok(32'd2);
    tick();
    opA   = '0;
    opB   = '0;
    btk.n = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    checks++;
    if (stallCnt !== 4'd14) begin
      errors++;
      $display("FAIL sat_pre: cnt=%0d want 14", stallCnt);
    end
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (stallCnt !== 4'd15) begin
      errors++;
      $display("FAIL sat_20: cnt=%0d want 15", stallCnt);
    end
    tick();
    tick();
    checks++;
    if (stallCnt !== 4'd15 || en !== 1'b1) begin
      errors++;
      $display("FAIL sat_hold: cnt=%0d en=%b want 15 1", stallCnt, en);
    end
    btk.n = 1'b0;
    tick();
  endtask

  task automatic test_midop_reset();
    do_reset();
    opB = tok(32'd7);
    tick();
    opB = '0;
    checks++;
    if (nackB !== 1'b1 || nackA !== 1'b0 || en !== 1'b0) begin
      errors++;
      $display("FAIL mid_holdB: nA=%b nB=%b en=%b want 0 1 0", nackA, nackB, en);
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    checks++;
    if (nackA !== 1'b0 || nackB !== 1'b0 || outB.d !== 32'd0) begin
      errors++;
      $display("FAIL mid_rst: nA=%b nB=%b Bd=%0d want 0 0 0", nackA, nackB, outB.d);
    end
    opA = tok(32'd3);
    tick();
    opA = '0;
    checks++;
    if (nackA !== 1'b1 || nackB !== 1'b0 || en !== 1'b0) begin
      errors++;
      $display("FAIL mid_holdA: nA=%b nB=%b en=%b want 1 0 0", nackA, nackB, en);
    end
    opB = tok(32'd8);
    tick();
    opB = '0;
    checks++;
    if (en !== 1'b1 || outA.d !== 32'd3 || outB.d !== 32'd8) begin
      errors++;
      $display("FAIL mid_pair: en=%b A=%0d B=%0d want 1 3 8", en, outA.d, outB.d);
    end
  endtask

  initial begin
    reset = 1'b0;
    opA   = '0;
    opB   = '0;
    btk   = '0;
    test_reset();
    test_pairing();
    test_back_to_back();
    test_backpressure();
    test_saturation();
    test_midop_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
